// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-mapped I/O bus: command encodings,
// master FSM states and the lab responder's I/O addresses.
package mem_bus_pkg;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   typedef enum logic [2:0] {IDLE, READ, WRITE, ERR, RESP} mm_state_t;

   localparam logic [8:0] LED_ADDR = 9'h100;
   localparam logic [8:0] SW_ADDR  = 9'h140;

endpackage

// File: rtl/mem_master.sv
// Single-outstanding bus initiator: turns datapath load/store requests into
// mem_cmd cycles. Define MEM_MASTER_PERF_EN to add rd_count/wr_count outputs.
module mem_master
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
`ifdef MEM_MASTER_PERF_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   localparam logic [2:0] LAT = 3'(READ_LAT);

   mm_state_t         state_reg;
   logic [2:0]        cnt_reg;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              write_q;
   logic              err_q;

   // Bus and response outputs are a registered decode of the state, so every
   // phase appears one cycle after the state enters it; read_data is sampled
   // at the end of the last visible MREAD cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         err_q      <= 1'b0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         mem_cmd    <= MNONE;
         mem_addr   <= '0;
         write_data <= '0;
`ifdef MEM_MASTER_PERF_EN
         rd_count   <= '0;
         wr_count   <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         mem_cmd   <= MNONE;
         req_ready <= 1'b0;
         case (state_reg)
            READ: begin
               mem_cmd  <= MREAD;
               mem_addr <= addr_q;
            end
            WRITE: begin
               mem_cmd    <= MWRITE;
               mem_addr   <= addr_q;
               write_data <= wdata_q;
            end
            RESP: begin
               rsp_valid <= 1'b1;
               rsp_err   <= err_q;
               rsp_rdata <= (err_q || write_q) ? '0 : read_data;
            end
            default: ;
         endcase

         case (state_reg)
            IDLE: begin
               if (req_valid && req_ready) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  write_q <= req_write;
                  err_q   <= ~req_addr[ADDR_W-1];
                  cnt_reg <= LAT;
                  if (!req_addr[ADDR_W-1])
                     state_reg <= ERR;
                  else if (req_write)
                     state_reg <= WRITE;
                  else
                     state_reg <= READ;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            READ: begin
               if (cnt_reg == 3'd0) begin
                  state_reg <= RESP;
`ifdef MEM_MASTER_PERF_EN
                  if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
`endif
               end else begin
                  cnt_reg <= cnt_reg - 3'd1;
               end
            end
            WRITE: begin
               state_reg <= RESP;
`ifdef MEM_MASTER_PERF_EN
               if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
`endif
            end
            ERR:     state_reg <= RESP;
            RESP:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: lab RAM/LEDR/SW responder with one-cycle read latency,
// a vector table, hand sequences and random traffic against a transaction model.
module tb_mem_master;
   import mem_bus_pkg::*;

   localparam int ADDR_W   = 9;
   localparam int DATA_W   = 16;
   localparam int READ_LAT = 1;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [1:0]        mem_cmd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
`ifdef MEM_MASTER_PERF_EN
   logic [15:0]       rd_count;
   logic [15:0]       wr_count;
`endif

   mem_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data),
      .read_data(read_data)
`ifdef MEM_MASTER_PERF_EN
      , .rd_count(rd_count), .wr_count(wr_count)
`endif
   );

   always #5 clk = ~clk;

   // Responder: RAM 0x100-0x1FF, LEDR latch on 0x100, switches read at 0x140.
   logic [15:0] ram [0:255] = '{default: 16'h0000};
   logic [7:0]  ledr = 8'h00;
   logic [7:0]  sw = 8'h00;
   logic [15:0] rd_pipe = 16'hDEAD;
   assign read_data = rd_pipe;

   always @(posedge clk) begin
      if (mem_cmd == MWRITE) begin
         ram[mem_addr[7:0]] <= write_data;
         if (mem_addr == LED_ADDR) ledr <= write_data[7:0];
      end
      if (mem_cmd == MREAD)
         rd_pipe <= (mem_addr == SW_ADDR) ? {8'h00, sw} : ram[mem_addr[7:0]];
      else
         rd_pipe <= 16'hDEAD;
   end

   // Reference model of the memory contents seen by the datapath.
   logic [15:0] ref_mem [0:255] = '{default: 16'h0000};
   int checks = 0;
   int errors = 0;
   int exp_rd_cnt = 0;
   int exp_wr_cnt = 0;

   // Protocol monitors sampled on the falling edge.
   int acc_cnt = 0, rsp_cnt = 0, gap_viol = 0, ready_viol = 0;
   logic [1:0] prev_cmd = MNONE;
   always @(negedge clk) begin
      if (reset) begin
         if (req_valid && req_ready) acc_cnt++;
         if (rsp_valid) rsp_cnt++;
         if (prev_cmd != MNONE && mem_cmd != MNONE &&
             (prev_cmd != mem_cmd || mem_cmd == MWRITE)) gap_viol++;
         if (req_ready && (mem_cmd != MNONE || rsp_valid)) ready_viol++;
      end
      prev_cmd = mem_cmd;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_read(input logic [8:0] a);
      return (a == SW_ADDR) ? {8'h00, sw} : ref_mem[a[7:0]];
   endfunction

   // Call at posedge+#1. Issues one request and checks bus and response.
   task automatic run_txn(input string name, input logic wr, input logic [8:0] a,
                          input logic [15:0] d, input logic [15:0] exp_rd,
                          input logic exp_err, input int exp_lat, input int exp_bus);
      int waited = 0;
      int lat = -1;
      int bus_n = 0;
      logic bus_ok = 1'b1;
      logic [1:0] exp_cmd = wr ? MWRITE : MREAD;
      req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
      while (!req_ready && waited < 30) begin
         @(posedge clk); #1; waited++;
      end
      if (!req_ready) begin
         req_valid = 1'b0;
         check({name, "_accept_timeout"}, 32'd0, 32'd1);
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (rsp_valid) begin
            lat = cyc;
            if (mem_cmd != MNONE) bus_ok = 1'b0;
            break;
         end
         if (mem_cmd != MNONE) begin
            bus_n++;
            if (mem_cmd != exp_cmd || mem_addr != a || (wr && write_data != d)) bus_ok = 1'b0;
         end
         @(posedge clk); #1;
      end
      $display("txn %s wr=%0d addr=%03h wdata=%04h -> rdata=%04h err=%0d lat=%0d bus=%0d",
               name, wr, a, d, rsp_rdata, rsp_err, lat, bus_n);
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_bus_cycles"}, 32'(bus_n), 32'(exp_bus));
      check({name, "_bus_fields"}, {31'd0, bus_ok}, 32'd1);
      check({name, "_rdata"}, {16'd0, rsp_rdata}, {16'd0, exp_rd});
      check({name, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      @(posedge clk); #1;
      check({name, "_single_pulse"}, {31'd0, rsp_valid}, 32'd0);
      if (!exp_err) begin
         if (wr) begin ref_mem[a[7:0]] = d; exp_wr_cnt++; end
         else exp_rd_cnt++;
      end
   endtask

   typedef struct {
      logic        wr;
      logic [8:0]  addr;
      logic [15:0] wdata;
      logic [7:0]  sw;
      logic [15:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_bus;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int a0, r0, seen;
      vecs[0] = '{1'b1, 9'h100, 16'h00A5, 8'h00, 16'h0000, 1'b0, 2, 1};
      vecs[1] = '{1'b0, 9'h140, 16'h0000, 8'h3C, 16'h003C, 1'b0, 3, 2};
      vecs[2] = '{1'b1, 9'h1F0, 16'hBEEF, 8'h3C, 16'h0000, 1'b0, 2, 1};
      vecs[3] = '{1'b0, 9'h1F0, 16'h0000, 8'h3C, 16'hBEEF, 1'b0, 3, 2};
      vecs[4] = '{1'b0, 9'h040, 16'h0000, 8'h3C, 16'h0000, 1'b1, 2, 0};
      vecs[5] = '{1'b1, 9'h1FF, 16'hFFFF, 8'h3C, 16'h0000, 1'b0, 2, 1};
      vecs[6] = '{1'b0, 9'h1FF, 16'h0000, 8'h3C, 16'hFFFF, 1'b0, 3, 2};
      vecs[7] = '{1'b1, 9'h0FF, 16'h1234, 8'h3C, 16'h0000, 1'b1, 2, 0};
      vecs[8] = '{1'b0, 9'h1F0, 16'h0000, 8'h3C, 16'hBEEF, 1'b0, 3, 2};

      // Reset values
      #12;
      check("rst_mem_cmd", {30'd0, mem_cmd}, {30'd0, MNONE});
      check("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
      check("rst_write_data", {16'd0, write_data}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         sw = vecs[i].sw;
         run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_bus);
      end
      check("ledr_value", {24'd0, ledr}, 32'h000000A5);

      // Held req_valid: one accept per response, spaced by the full access.
      a0 = acc_cnt; r0 = rsp_cnt;
      req_write = 1'b0; req_addr = 9'h1F0; req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
      req_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
      $display("txn hold_valid accepts=%0d responses=%0d", acc_cnt - a0, rsp_cnt - r0);
      check("hold_accepts", 32'(acc_cnt - a0), 32'd4);
      check("hold_responses", 32'(rsp_cnt - r0), 32'd4);
      check("hold_rdata", {16'd0, rsp_rdata}, 32'h0000BEEF);

      // Reset during the first MREAD cycle aborts the access.
      req_write = 1'b0; req_addr = 9'h1F0; req_valid = 1'b1;
      seen = 0;
      while (!req_ready && seen < 30) begin @(posedge clk); #1; seen++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("abort_pre_mread", {30'd0, mem_cmd}, {30'd0, MREAD});
      reset = 1'b0;
      #1;
      check("abort_mem_cmd", {30'd0, mem_cmd}, {30'd0, MNONE});
      check("abort_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      exp_rd_cnt = 0; exp_wr_cnt = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid) seen++;
         @(posedge clk); #1;
      end
      $display("txn reset_abort rsp_pulses=%0d", seen);
      check("abort_no_rsp", 32'(seen), 32'd0);
      run_txn("post_abort_wr", 1'b1, 9'h1A0, 16'h5A5A, 16'h0000, 1'b0, 2, 1);
      run_txn("post_abort_rd", 1'b0, 9'h1A0, 16'h0000, 16'h5A5A, 1'b0, READ_LAT + 2, READ_LAT + 1);

      // Random traffic against the transaction model.
      for (int i = 0; i < 80; i++) begin
         logic wr;
         logic [8:0] a;
         logic [15:0] d;
         int sel;
         wr = 1'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 9));
         d = 16'($urandom);
         sw = 8'($urandom);
         if (sel == 0) a = 9'($urandom_range(0, 255));
         else if (sel == 1) a = SW_ADDR;
         else a = 9'h1C0 + 9'($urandom_range(0, 15));
         if (!a[8])
            run_txn($sformatf("rnd%0d", i), wr, a, d, 16'h0000, 1'b1, 2, 0);
         else if (wr)
            run_txn($sformatf("rnd%0d", i), wr, a, d, 16'h0000, 1'b0, 2, 1);
         else
            run_txn($sformatf("rnd%0d", i), wr, a, d, ref_read(a), 1'b0,
                    READ_LAT + 2, READ_LAT + 1);
      end

      check("bus_gap_violations", 32'(gap_viol), 32'd0);
      check("ready_while_busy", 32'(ready_viol), 32'd0);
`ifdef MEM_MASTER_PERF_EN
      check("perf_rd_count", {16'd0, rd_count}, 32'(exp_rd_cnt));
      check("perf_wr_count", {16'd0, wr_count}, 32'(exp_wr_cnt));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
